// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_arb_pkg;

  // Arbiter sequencing states, one transaction per pass IDLE..DONE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } arb_state_t;

  // Bit positions inside req_err.
  localparam int ERR_ACK     = 0;
  localparam int ERR_TIMEOUT = 1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first asserted request after 'last'.
module rr_priority_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last,
  output logic               any_req,
  output logic [2:0]         pick
);

  // Scan last+1, last+2, ... modulo NUM_REQ and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    any_req = 1'b0;
    pick    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_req && req[i] && (((int'(last) + k) % NUM_REQ) == i)) begin
          any_req = 1'b1;
          pick    = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Round-robin scheduler sharing one i2c_master among NUM_REQ requesters.
module i2c_request_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [7*NUM_REQ-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [32*NUM_REQ-1:0] req_data_wr,
  input  logic [8*NUM_REQ-1:0]  req_nbytes,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [1:0]            req_err,
  output logic [2:0]            active_id,
  output logic                  busy_out,
  output logic                  m_ena,
  output logic [6:0]            m_addr,
  output logic                  m_rw,
  output logic [31:0]           m_data_wr,
  output logic [7:0]            m_nbytes,
  input  logic                  m_busy,
  input  logic                  m_ack_error,
  input  logic [7:0]            m_byte_counter
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state, state_nxt;
  logic [2:0]    grant_id, last_id;
  logic [6:0]    addr_q;
  logic          rw_q;
  logic [31:0]   data_q;
  logic [7:0]    nbytes_q;
  logic [TW-1:0] tmo_cnt;
  logic          timeout_flag, ack_sticky;
  logic          pick_any;
  logic [2:0]    pick_id;
  logic [6:0]    pick_addr;
  logic          pick_rw;
  logic [31:0]   pick_data;
  logic [7:0]    pick_nbytes;
  logic          timeout_hit, in_xfer, bytes_done;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .last    (last_id),
    .any_req (pick_any),
    .pick    (pick_id)
  );

  // Counter saturates at its last value, so an earlier timeout also ends a stuck DRAIN.
  assign timeout_hit = (tmo_cnt >= TMO_LAST);
  assign in_xfer     = (state == ST_START) || (state == ST_RUN) || (state == ST_DRAIN);
  assign bytes_done  = (m_byte_counter >= nbytes_q);

  // Select the winning requester's fields for the holding registers.
  always_comb begin
    pick_addr   = '0;
    pick_rw     = 1'b0;
    pick_data   = '0;
    pick_nbytes = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == 3'(i)) begin
        pick_addr   = req_addr[7*i +: 7];
        pick_rw     = req_rw[i];
        pick_data   = req_data_wr[32*i +: 32];
        pick_nbytes = req_nbytes[8*i +: 8];
      end
    end
  end

  // State register; async reset drops m_ena at once because outputs decode state.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode for one grant-to-completion pass.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_START;
      ST_START: begin
        if (timeout_hit) state_nxt = ST_DRAIN;
        else if (m_busy) state_nxt = ST_RUN;
      end
      ST_RUN:   if (timeout_hit || bytes_done) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!m_busy || timeout_hit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Holding registers, round-robin pointer, timeout counter and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: holding registers are reset too, so master controls read 0 out of reset.
      grant_id     <= '0;
      last_id      <= 3'(NUM_REQ - 1);
      addr_q       <= '0;
      rw_q         <= 1'b0;
      data_q       <= '0;
      nbytes_q     <= '0;
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
      ack_sticky   <= 1'b0;
    end else begin
      if (state == ST_IDLE && pick_any) begin
        grant_id <= pick_id;
        addr_q   <= pick_addr;
        rw_q     <= pick_rw;
        data_q   <= pick_data;
        nbytes_q <= (pick_nbytes == 8'd0) ? 8'd1 : pick_nbytes;
      end
      if (state == ST_GRANT) begin
        last_id      <= grant_id;
        tmo_cnt      <= '0;
        timeout_flag <= 1'b0;
        ack_sticky   <= 1'b0;
      end else if (in_xfer) begin
        if (timeout_hit) timeout_flag <= 1'b1;
        else             tmo_cnt      <= tmo_cnt + 1'b1;
        if (m_ack_error) ack_sticky <= 1'b1;
      end
    end
  end

  // Output decode: handshake pulses, status and master enable.
  always_comb begin
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;
    m_ena     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == ST_GRANT) && (grant_id == 3'(i));
      req_done[i]  = (state == ST_DONE)  && (grant_id == 3'(i));
    end
    if (state == ST_DONE) begin
      req_err[ERR_ACK]     = ack_sticky;
      req_err[ERR_TIMEOUT] = timeout_flag;
    end
    if (state == ST_START) m_ena = 1'b1;
    if (state == ST_RUN)   m_ena = !bytes_done;
  end

  assign busy_out  = (state != ST_IDLE);
  assign active_id = busy_out ? grant_id : 3'd0;
  assign m_addr    = addr_q;
  assign m_rw      = rw_q;
  assign m_data_wr = data_q;
  assign m_nbytes  = nbytes_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Directed bench for i2c_request_arbiter with a scoreboard of grants and completions.
module tb_i2c_request_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 50;

  typedef struct packed {
    logic [2:0] id;
    logic [1:0] err;
  } done_t;

  logic            clock;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [7*NR-1:0] req_addr;
  logic [NR-1:0]   req_rw;
  logic [32*NR-1:0] req_data_wr;
  logic [8*NR-1:0] req_nbytes;
  logic [NR-1:0]   req_ready, req_done;
  logic [1:0]      req_err;
  logic [2:0]      active_id;
  logic            busy_out, m_ena, m_rw;
  logic [6:0]      m_addr;
  logic [31:0]     m_data_wr;
  logic [7:0]      m_nbytes;
  logic            m_busy, m_ack_error;
  logic [7:0]      m_byte_counter;

  int total, bad, n_ready, n_done;
  logic [2:0] grant_q[$];
  done_t      done_q[$];
  logic [2:0] mon_id;
  done_t      mon_done;
  logic       mdl_en;
  logic [1:0] mdl_tick;

  i2c_request_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_rw         (req_rw),
    .req_data_wr    (req_data_wr),
    .req_nbytes     (req_nbytes),
    .req_ready      (req_ready),
    .req_done       (req_done),
    .req_err        (req_err),
    .active_id      (active_id),
    .busy_out       (busy_out),
    .m_ena          (m_ena),
    .m_addr         (m_addr),
    .m_rw           (m_rw),
    .m_data_wr      (m_data_wr),
    .m_nbytes       (m_nbytes),
    .m_busy         (m_busy),
    .m_ack_error    (m_ack_error),
    .m_byte_counter (m_byte_counter)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Minimal i2c_master: busy on ena, one byte every 3 cycles while ena, idle 3 cycles after ena drops.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_byte_counter <= 8'd0; mdl_tick <= 2'd0;
    end else if (!m_busy) begin
      if (m_ena && mdl_en) begin
        m_busy <= 1'b1; m_byte_counter <= 8'd0; mdl_tick <= 2'd0;
      end
    end else if (mdl_tick == 2'd2) begin
      mdl_tick <= 2'd0;
      if (m_ena) m_byte_counter <= m_byte_counter + 8'd1;
      else       m_busy <= 1'b0;
    end else begin
      mdl_tick <= mdl_tick + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input logic [2:0] id);
    onehot = NR'(1) << id;
  endfunction

  // Scoreboard: pop expected grant/completion whenever the DUT pulses one.
  always @(negedge clock) begin
    if (!reset) begin
      if (req_ready != '0) begin
        n_ready++;
        if (grant_q.size() == 0) check("ready_unexpected", 64'(req_ready), 64'd0);
        else begin
          mon_id = grant_q.pop_front();
          check("grant_order", 64'(req_ready), 64'(onehot(mon_id)));
        end
      end
      if (req_done != '0) begin
        n_done++;
        if (done_q.size() == 0) check("done_unexpected", 64'(req_done), 64'd0);
        else begin
          mon_done = done_q.pop_front();
          check("done_status", 64'({req_done, req_err}), 64'({onehot(mon_done.id), mon_done.err}));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic expect_txn(input logic [2:0] id, input logic [1:0] err);
    grant_q.push_back(id);
    done_q.push_back({id, err});
  endtask

  task automatic set_req(input int id, input logic [6:0] a, input logic rw,
                         input logic [31:0] d, input logic [7:0] nb);
    req_addr[7*id +: 7]     = a;
    req_rw[id]              = rw;
    req_data_wr[32*id +: 32] = d;
    req_nbytes[8*id +: 8]   = nb;
    req_valid[id]           = 1'b1;
  endtask

  // Drop the request and scramble its fields; the DUT must use its own copies.
  task automatic clr_req(input int id);
    req_valid[id]            = 1'b0;
    req_addr[7*id +: 7]      = 7'($urandom);
    req_rw[id]               = 1'($urandom);
    req_data_wr[32*id +: 32] = $urandom;
    req_nbytes[8*id +: 8]    = 8'($urandom);
  endtask

  task automatic wait_ready(input int target);
    int k = 0;
    while (n_ready < target && k < 300) begin tick(); k++; end
    check("ready_wait", 64'(n_ready >= target), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 300) begin tick(); k++; end
    check("done_wait", 64'(n_done >= target), 64'd1);
  endtask

  task automatic wait_ena(input logic val, input string tag);
    int k = 0;
    while (m_ena !== val && k < 300) begin tick(); k++; end
    check(tag, 64'(m_ena), 64'(val));
  endtask

  task automatic wait_busy();
    int k = 0;
    while (m_busy !== 1'b1 && k < 300) begin tick(); k++; end
    check("busy_wait", 64'(m_busy), 64'd1);
  endtask

  initial begin
    int cnt;
    int nd;
    total = 0; bad = 0; n_ready = 0; n_done = 0;
    req_valid = '0; req_addr = '0; req_rw = '0; req_data_wr = '0; req_nbytes = '0;
    m_ack_error = 1'b0; mdl_en = 1'b1; reset = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_ready",  64'(req_ready), 64'd0);
    check("rst_done",   64'(req_done),  64'd0);
    check("rst_err",    64'(req_err),   64'd0);
    check("rst_busy",   64'(busy_out),  64'd0);
    check("rst_ena",    64'(m_ena),     64'd0);
    check("rst_active", 64'(active_id), 64'd0);
    check("rst_addr",   64'(m_addr),    64'd0);
    check("rst_nbytes", 64'(m_nbytes),  64'd0);
    reset = 1'b0;
    tick();

    // Single write from requester 0
    expect_txn(3'd0, 2'b00);
    set_req(0, 7'h50, 1'b0, 32'hA5C3_0F12, 8'd2);
    tick();
    check("t1_ready_t1", 64'(req_ready), 64'h1);
    clr_req(0);
    tick();
    check("t1_ena_t2", 64'(m_ena),     64'd1);
    check("t1_addr",   64'(m_addr),    64'h50);
    check("t1_rw",     64'(m_rw),      64'd0);
    check("t1_data",   64'(m_data_wr), 64'hA5C3_0F12);
    check("t1_nbytes", 64'(m_nbytes),  64'd2);
    check("t1_active", 64'(active_id), 64'd0);
    check("t1_busy",   64'(busy_out),  64'd1);
    wait_ena(1'b0, "t1_ena_drop");
    check("t1_bc_at_drop", 64'(m_byte_counter), 64'd2);
    wait_done(1);

    // Prior grant to 1, then 1 and 3 held together: order 3,1,3,1
    expect_txn(3'd1, 2'b00);
    set_req(1, 7'h21, 1'b1, 32'h0, 8'd1);
    wait_ready(2);
    clr_req(1);
    wait_done(2);
    expect_txn(3'd3, 2'b00);
    expect_txn(3'd1, 2'b00);
    expect_txn(3'd3, 2'b00);
    expect_txn(3'd1, 2'b00);
    set_req(1, 7'h21, 1'b1, 32'h0, 8'd1);
    set_req(3, 7'h33, 1'b0, 32'h1234_5678, 8'd2);
    wait_done(3);
    cnt = 0;
    while (m_ena !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    check("b2b_gap", 64'(cnt), 64'd3);
    wait_done(6);
    clr_req(1);
    clr_req(3);

    // Ack error pulse during RUN
    expect_txn(3'd2, 2'b01);
    set_req(2, 7'h3C, 1'b0, 32'hCAFE_F00D, 8'd3);
    wait_ready(7);
    clr_req(2);
    wait_busy();
    tick();
    m_ack_error = 1'b1;
    tick();
    m_ack_error = 1'b0;
    wait_done(7);

    // Timeout: master never becomes busy
    mdl_en = 1'b0;
    expect_txn(3'd1, 2'b10);
    set_req(1, 7'h11, 1'b1, 32'h0, 8'd4);
    wait_ready(8);
    clr_req(1);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (m_ena === 1'b1) cnt++;
      else break;
    end
    check("tmo_ena_cycles", 64'(cnt), 64'(TMO));
    wait_done(8);
    mdl_en = 1'b1;

    // Zero byte count treated as one
    expect_txn(3'd0, 2'b00);
    set_req(0, 7'h2A, 1'b0, 32'h0000_00EE, 8'd0);
    wait_ready(9);
    clr_req(0);
    tick();
    check("t5_nbytes", 64'(m_nbytes), 64'd1);
    check("t5_ena",    64'(m_ena),    64'd1);
    wait_ena(1'b0, "t5_ena_drop");
    check("t5_bc_at_drop", 64'(m_byte_counter), 64'd1);
    wait_done(9);

    // Reset during RUN: no completion, pointer back to requester 0 first
    grant_q.push_back(3'd0);
    set_req(0, 7'h44, 1'b1, 32'h0, 8'd5);
    wait_ready(10);
    clr_req(0);
    wait_busy();
    tick();
    nd = n_done;
    set_req(0, 7'h05, 1'b0, 32'h0, 8'd1);
    set_req(1, 7'h06, 1'b0, 32'h0, 8'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_ena",  64'(m_ena),    64'd0);
    check("rst_mid_busy", 64'(busy_out), 64'd0);
    tick();
    tick();
    check("rst_mid_no_done", 64'(n_done), 64'(nd));
    expect_txn(3'd0, 2'b00);
    expect_txn(3'd1, 2'b00);
    reset = 1'b0;
    wait_ready(11);
    clr_req(0);
    wait_ready(12);
    clr_req(1);
    wait_done(nd + 2);
    repeat (4) tick();

    check("grant_q_empty", 64'(grant_q.size()), 64'd0);
    check("done_q_empty",  64'(done_q.size()),  64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_request_arbiter.md
# i2c_request_arbiter

Round-robin scheduler sharing one `i2c_master` among `NUM_REQ` independent requesters, e.g. several Avalon bridges or sensor pollers. It latches one requester's transaction (address, direction, write word, byte count), drives the master's `ena`/configuration inputs, and tracks `busy`/`byte_counter` to completion. It then reports done, ACK error or timeout back to that requester. It sits between the requester logic and `i2c_master`, replacing direct `ena` handling.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `TIMEOUT_CYCLES`, 1_000_000: max clock cycles from grant to completion before abort
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  NUM_REQ  requester i has a pending transaction
- `req_addr`  in  7*NUM_REQ  slave address, slice i = [7i+6:7i]
- `req_rw`  in  NUM_REQ  1 = read, 0 = write
- `req_data_wr`  in  32*NUM_REQ  write data word
- `req_nbytes`  in  8*NUM_REQ  byte count, 0 treated as 1
- `req_ready`  out  NUM_REQ  one-cycle pulse: request i accepted and latched
- `req_done`  out  NUM_REQ  one-cycle pulse: transaction i finished
- `req_err`  out  2  status valid with `req_done`: bit0 ack_error, bit1 timeout
- `active_id`  out  3  index of the granted requester (valid while `busy_out`)
- `busy_out`  out  1  arbiter owns the master
- `m_ena`, `m_addr[6:0]`, `m_rw`, `m_data_wr[31:0]`, `m_nbytes[7:0]`  out  master controls
- `m_busy`, `m_ack_error`  in  1 each; `m_byte_counter`  in  8

## Operation
- States: IDLE, GRANT, START, RUN, DRAIN, DONE.
- IDLE: if any `req_valid`, pick the first set bit scanning from `last+1` modulo `NUM_REQ` (round-robin). Then go to GRANT.
- GRANT: latch the winner's fields into holding registers, pulse `req_ready[i]`, load the timeout counter to 0, store `last=i`. Next state START.
- START: `m_ena=1`; wait for `m_busy=1`, then go to RUN.
- RUN: `m_ena=1` while `m_byte_counter < nbytes_latched`. When `>=`, deassert `m_ena` and go to DRAIN.
- DRAIN: `m_ena=0`; wait `m_busy=0`, then go to DONE.
- DONE: pulse `req_done[i]`, `req_err={timeout_flag, ack_sticky}`, then go to IDLE.
- `ack_sticky` captures any `m_ack_error=1` sampled during START..DRAIN.
- Timeout: the counter increments every cycle in START/RUN/DRAIN. On reaching `TIMEOUT_CYCLES` in START or RUN, set `timeout_flag`, drop `m_ena` and go to DRAIN. A timeout in DRAIN goes straight to DONE with `timeout_flag`.
- Master control outputs come from the holding registers only, so requester inputs may change after `req_ready`.
- `req_valid` dropped before grant: the request is simply not chosen. No cancellation after grant.

## Timing
- Reset values: all outputs 0, state IDLE, `last=NUM_REQ-1` (so requester 0 wins first).
- Request seen in IDLE at cycle t: `req_ready` at t+1, `m_ena` high from t+2.
- `req_done` comes exactly 1 cycle after `m_busy` is sampled low in DRAIN.
- Back-to-back: the earliest next `m_ena` is 3 cycles after `req_done`, giving at least 2 idle cycles with `m_ena=0` between transactions.
- Simultaneous requests: strict round-robin, with no requester granted twice while another is waiting.
- `nbytes=0` is latched as 1. `m_byte_counter` compares as unsigned 8-bit.
- Asynchronous reset mid-transaction: `m_ena` goes low immediately; no `req_done` is issued.

## Structure
- Package `i2c_arb_pkg`: state enum and `ERR_ACK`/`ERR_TIMEOUT` bit indices.
- Sub-module `rr_priority_pick` (combinational round-robin picker, `NUM_REQ` parameter). The FSM, holding registers and timeout counter live in the top.

## Test plan
- Single write, req 0, `addr=0x50`, `nbytes=2`; master model raises busy and counts to 2 → `req_ready[0]` at t+1, `m_ena` low once `byte_counter=2`, `req_done[0]` with `req_err=0`.
- Requests 1 and 3 asserted together and held, after a prior grant to 1 → grant order 3, 1, 3, 1.
- Master model asserts `m_ack_error` for one cycle in RUN → `req_err=2'b01`.
- `TIMEOUT_CYCLES=50`, master never raises busy → `m_ena` drops at cycle 50 after START, `req_done` with `req_err=2'b10`.
- `req_nbytes=0` → `m_nbytes=1`, `m_ena` drops after `byte_counter=1`.
- Reset asserted in RUN → `m_ena=0` in the same cycle, no `req_done`; after release, a pending req 0 is granted first.
